// File: rtl/udp_tx_framer_pkg.sv
// udp_tx_framer_pkg: shared UDP constants, TX state encoding and one's-complement add helper.
package udp_tx_framer_pkg;
  localparam int UDP_HDR_LEN = 8;
  typedef enum logic [2:0] {IDLE, BUFFER, DROP, FINALIZE, HEADER, PAYLOAD} tx_state_t;
  // 17-bit add with end-around carry; inputs <= 16'hFFFF keep the fold from carrying again
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction
endpackage

// File: rtl/udp_tx_framer_if.sv
// udp_tx_framer_if: payload-in / datagram-out handshake bundle for the UDP TX framer.
interface udp_tx_framer_if;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic        payload_valid;
  logic [7:0]  payload_data;
  logic        payload_last;
  logic        payload_ready;
  logic        data_ready_in;
  logic        data_valid_out;
  logic [7:0]  data_out;
  logic        packet_start_out;
  logic        packet_last_out;
  logic        overflow_err;
  modport master (
    output src_port, dst_port, payload_valid, payload_data, payload_last, data_ready_in,
    input  payload_ready, data_valid_out, data_out, packet_start_out, packet_last_out, overflow_err
  );
  modport slave (
    input  src_port, dst_port, payload_valid, payload_data, payload_last, data_ready_in,
    output payload_ready, data_valid_out, data_out, packet_start_out, packet_last_out, overflow_err
  );
endinterface

// File: rtl/udp_tx_framer_payload_buffer.sv
// udp_tx_framer_payload_buffer: simple dual-port byte RAM, sync write, registered read.
module udp_tx_framer_payload_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: store-and-forward UDP datagram builder (header + checksum + buffered payload).
module udp_tx_framer
  import udp_tx_framer_pkg::*;
#(
  parameter int MAX_PAYLOAD = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  udp_tx_framer_if.slave bus
);
  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam logic [CW-1:0] MAXC = CW'(MAX_PAYLOAD);
  tx_state_t r_state, w_next;
  logic [CW-1:0] r_count, r_idx, w_idx_inc;
  logic [15:0] r_src, r_dst, r_acc, r_csum, w_len, w_term, w_fin;
  logic r_ovf, w_accept, w_xfer, w_full, w_hdr_end, w_pl_end, w_we, w_re;
  logic [AW-1:0] w_raddr;
  logic [7:0] w_rdata;
  logic [63:0] w_hdr;
  assign w_accept  = bus.payload_valid && bus.payload_ready;
  assign w_xfer    = bus.data_valid_out && bus.data_ready_in;
  assign w_full    = r_count == MAXC;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_hdr_end = r_state == HEADER && r_idx == CW'(UDP_HDR_LEN - 1);
  assign w_pl_end  = r_state == PAYLOAD && w_idx_inc == r_count;
  assign w_len     = 16'(UDP_HDR_LEN) + 16'(r_count);
  assign w_term    = r_count[0] ? {8'h00, bus.payload_data} : {bus.payload_data, 8'h00};
  assign w_fin     = ones_add16(ones_add16(ones_add16(r_acc, r_src), r_dst), w_len);
  assign w_hdr     = {r_src, r_dst, w_len, r_csum};
  assign w_we      = w_accept && (r_state == IDLE || (r_state == BUFFER && !w_full));
  // rd_data always holds the byte to show next: first read fires on the last header transfer
  assign w_re      = w_xfer && (w_hdr_end || r_state == PAYLOAD);
  assign w_raddr   = w_hdr_end ? '0 : w_idx_inc[AW-1:0];
  udp_tx_framer_payload_buffer #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (bus.payload_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = bus.payload_last ? FINALIZE : BUFFER;
      BUFFER:   if (w_accept) w_next = w_full ? (bus.payload_last ? IDLE : DROP)
                                              : (bus.payload_last ? FINALIZE : BUFFER);
      DROP:     if (w_accept && bus.payload_last) w_next = IDLE;
      FINALIZE: w_next = HEADER;
      HEADER:   if (w_xfer && w_hdr_end) w_next = PAYLOAD;
      PAYLOAD:  if (w_xfer && w_pl_end) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.payload_ready    = r_state == IDLE || r_state == BUFFER || r_state == DROP;
    bus.data_valid_out   = r_state == HEADER || r_state == PAYLOAD;
    bus.data_out         = r_state == HEADER ? w_hdr[{3'd7 - r_idx[2:0], 3'b000} +: 8]
                         : r_state == PAYLOAD ? w_rdata : 8'h00;
    bus.packet_start_out = r_state == HEADER && r_idx == '0;
    bus.packet_last_out  = w_pl_end;
    bus.overflow_err     = r_ovf;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_count <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_csum  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= w_accept && bus.payload_last && (r_state == DROP || (r_state == BUFFER && w_full));
      if (w_accept && r_state == IDLE) begin
        r_src <= bus.src_port;
        r_dst <= bus.dst_port;
      end
      if (w_we) begin
        r_count <= r_count + 1'b1;
        r_acc   <= ones_add16(r_acc, w_term);
      end
      // a zero checksum means "none" in UDP, so send its other one's-complement form
      if (r_state == FINALIZE) r_csum <= w_fin == 16'hFFFF ? 16'hFFFF : ~w_fin;
      if (w_xfer) r_idx <= (w_hdr_end || w_pl_end) ? '0 : w_idx_inc;
      if (r_state != IDLE && w_next == IDLE) begin
        r_count <= '0;
        r_acc   <= '0;
      end
    end
endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: randomized self-checking bench against a queue-based UDP datagram model.
module tb_udp_tx_framer;
  localparam int MAXP = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0, ovf_cnt = 0, cyc = 0, last_cyc = 0, start_cyc = 0;
  bit stall = 1'b0, seen_start = 1'b0, prev_stall = 1'b0;
  logic [9:0] prev;
  logic [7:0] pl[$];
  logic [9:0] exp_q[$], obs_q[$];
  udp_tx_framer_if bus();
  udp_tx_framer #(.MAX_PAYLOAD(MAXP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask
  initial begin
    bus.data_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.data_ready_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.data_valid_out), 1);
        chk("hold_bits", {bus.packet_start_out, bus.packet_last_out, bus.data_out}, prev);
      end
      if (bus.data_valid_out) chk("busy_ready", 32'(bus.payload_ready), 0);
      if (bus.data_valid_out && bus.data_ready_in)
        obs_q.push_back({bus.packet_start_out, bus.packet_last_out, bus.data_out});
      if (bus.packet_start_out && !seen_start) begin
        seen_start = 1'b1;
        start_cyc = cyc;
      end
      prev_stall = bus.data_valid_out && !bus.data_ready_in;
      prev = {bus.packet_start_out, bus.packet_last_out, bus.data_out};
      ovf_cnt += int'(bus.overflow_err);
    end
  end
  function automatic void model(input logic [15:0] s, input logic [15:0] d);
    int unsigned sum;
    logic [15:0] len, cs;
    logic [7:0] hb[8];
    len = 16'(8 + pl.size());
    sum = s + d + len;
    foreach (pl[i]) sum += (i % 2 == 0) ? {pl[i], 8'h00} : {8'h00, pl[i]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~sum[15:0];
    if (cs == 16'h0000) cs = 16'hFFFF;
    hb = '{s[15:8], s[7:0], d[15:8], d[7:0], len[15:8], len[7:0], cs[15:8], cs[7:0]};
    exp_q.delete();
    foreach (hb[i]) exp_q.push_back({i == 0, 1'b0, hb[i]});
    foreach (pl[i]) exp_q.push_back({1'b0, i == pl.size() - 1, pl[i]});
  endfunction
  function automatic logic [31:0] obs_csum();
    return obs_q.size() >= 8 ? {16'h0, obs_q[6][7:0], obs_q[7][7:0]} : 32'hDEAD_BEEF;
  endfunction
  task automatic send(input logic [15:0] s, input logic [15:0] d);
    foreach (pl[i]) begin
      @(negedge clk);
      bus.src_port      = s;
      bus.dst_port      = d;
      bus.payload_valid = 1'b1;
      bus.payload_data  = pl[i];
      bus.payload_last  = i == pl.size() - 1;
      for (int t = 0; !bus.payload_ready; t++) begin
        if (t > 3000) begin
          chk("in_timeout", 0, 1);
          break;
        end
        @(negedge clk);
      end
    end
    last_cyc = cyc + 1;
    @(negedge clk);
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
  endtask
  task automatic run(input logic [15:0] s, input logic [15:0] d, input string tag);
    obs_q.delete();
    seen_start = 1'b0;
    model(s, d);
    send(s, d);
    for (int t = 0; obs_q.size() < exp_q.size() && t < 5000; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    chk($sformatf("%s_latency", tag), start_cyc - last_cyc, 1);
    foreach (exp_q[i])
      chk($sformatf("%s_b%0d", tag, i), i < obs_q.size() ? 32'(obs_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.payload_ready), 1);
    chk({tag, "_valid"}, 32'(bus.data_valid_out), 0);
    chk({tag, "_data"}, 32'(bus.data_out), 0);
    chk({tag, "_start"}, 32'(bus.packet_start_out), 0);
    chk({tag, "_last"}, 32'(bus.packet_last_out), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow_err), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.payload_valid = 1'b0;
    bus.payload_data  = 8'h00;
    bus.payload_last  = 1'b0;
    bus.src_port      = 16'h0;
    bus.dst_port      = 16'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run(16'h1234, 16'h5678, "t1");
    chk("t1_csum", obs_csum(), 32'h9341);
    pl = '{8'hAB};
    run(16'h1234, 16'h5678, "t2");
    chk("t2_csum", obs_csum(), 32'hEC49);
    pl = '{8'hFF, 8'hF5};
    run(16'h0000, 16'h0000, "t3");
    chk("t3_csum", obs_csum(), 32'hFFFF);
    pl.delete();
    for (int i = 0; i < MAXP + 3; i++) pl.push_back(8'($urandom));
    obs_q.delete();
    ovf_cnt = 0;
    send(16'h1111, 16'h2222);
    repeat (20) @(negedge clk);
    chk("ovf_pulses", ovf_cnt, 1);
    chk("ovf_no_output", obs_q.size(), 0);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run(16'h1234, 16'h5678, "t4_next");
    pl.delete();
    for (int i = 0; i < MAXP; i++) pl.push_back(8'($urandom));
    ovf_cnt = 0;
    run(16'($urandom), 16'($urandom), "tmax");
    chk("tmax_ovf", ovf_cnt, 0);
    stall = 1'b1;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run(16'h1234, 16'h5678, "t5");
    for (int n = 0; n < 10; n++) begin
      stall = 1'($urandom_range(0, 1));
      pl.delete();
      for (int i = 0, len = $urandom_range(1, 40); i < len; i++) pl.push_back(8'($urandom));
      run(16'($urandom), 16'($urandom), $sformatf("rnd%0d", n));
    end
    stall = 1'b0;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send(16'h1234, 16'h5678);
    for (int t = 0; !bus.packet_start_out && t < 100; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6_byte3", 32'(bus.data_out), 32'h78);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_idle_outputs("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(16'h1234, 16'h5678, "t6_after");
    chk("t6_csum", obs_csum(), 32'h9341);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
